// File: rtl/band_mix_sequencer.sv
// Mixes BANDS equalizer band words into one sample through a shared external
// saturating adder, one operand pair per cycle, with a sticky clip indication.
module band_mix_sequencer #(
    parameter int WIDTH = 16,
    parameter int BANDS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BANDS*WIDTH-1:0] band_data,
    input  logic [BANDS-1:0]       band_en,
    output logic [WIDTH-1:0]       sum_a,
    output logic [WIDTH-1:0]       sum_b,
    input  logic [WIDTH-1:0]       sum_y,
    output logic [WIDTH-1:0]       mix_out,
    output logic                   done,
    output logic                   busy,
    output logic                   clip
);

    localparam int IDX_W = (BANDS > 1) ? $clog2(BANDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [WIDTH-1:0]   r_band [BANDS];
    logic [BANDS-1:0]   r_en;
    logic [WIDTH-1:0]   r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic               r_clip_flag;
    logic [WIDTH-1:0]   r_mix;
    logic               r_clip_out;
    logic               r_done;
    logic               r_busy;

    logic [WIDTH-1:0]   w_band_sel;
    logic               w_en_sel;
    logic               w_last;
    logic [WIDTH:0]     w_ext_sum;
    logic               w_step_clip;

    assign w_last = (r_idx == IDX_W'(BANDS - 1));

    // Band/enable select by index; explicit compare avoids indexing past BANDS
    always_comb begin
        w_band_sel = '0;
        w_en_sel   = 1'b0;
        for (int k = 0; k < BANDS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_band_sel = r_band[k];
                w_en_sel   = r_en[k];
            end else begin
                w_band_sel = w_band_sel;
                w_en_sel   = w_en_sel;
            end
        end
    end

    // Adder operands: only driven during accumulation, zero otherwise
    always_comb begin
        sum_a = '0;
        sum_b = '0;
        if (r_state == ST_ACC) begin
            sum_a = r_acc;
            sum_b = w_en_sel ? w_band_sel : '0;
        end else begin
            sum_a = '0;
            sum_b = '0;
        end
    end

    // A step clipped when the exact sum disagrees with the adder's result
    assign w_ext_sum   = {sum_a[WIDTH-1], sum_a} + {sum_b[WIDTH-1], sum_b};
    assign w_step_clip = (r_state == ST_ACC) && (w_ext_sum != {sum_y[WIDTH-1], sum_y});

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_ACC;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (w_last) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_ACC;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State register plus busy/done, registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx != ST_IDLE);
            r_done  <= (w_state_nx == ST_DONE);
        end
    end

    // Band capture on an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < BANDS; k++) begin
                r_band[k] <= '0;
            end
            r_en <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            for (int k = 0; k < BANDS; k++) begin
                r_band[k] <= band_data[k*WIDTH +: WIDTH];
            end
            r_en <= band_en;
        end else begin
            r_en <= r_en;
        end
    end

    // Accumulator, index and sticky clip flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_idx       <= '0;
            r_clip_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_idx       <= '0;
                        r_clip_flag <= 1'b0;
                    end else begin
                        r_acc       <= r_acc;
                    end
                end
                ST_ACC: begin
                    r_acc       <= sum_y;
                    r_idx       <= r_idx + IDX_W'(1);
                    r_clip_flag <= r_clip_flag | w_step_clip;
                end
                ST_DONE: begin
                    r_acc <= r_acc;
                end
                default: begin
                    r_acc       <= '0;
                    r_idx       <= '0;
                    r_clip_flag <= 1'b0;
                end
            endcase
        end
    end

    // Result is published on the final step so it is valid alongside done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mix      <= '0;
            r_clip_out <= 1'b0;
        end else if ((r_state == ST_ACC) && w_last) begin
            r_mix      <= sum_y;
            r_clip_out <= r_clip_flag | w_step_clip;
        end else begin
            r_mix      <= r_mix;
            r_clip_out <= r_clip_out;
        end
    end

    assign mix_out = r_mix;
    assign clip    = r_clip_out;
    assign done    = r_done;
    assign busy    = r_busy;

endmodule

// File: doc/band_mix_sequencer.md
# band_mix_sequencer

Time-multiplexes one shared saturating adder to mix the equalizer band outputs into a single sample. The block captures one word per band on a start strobe, then feeds the adder one operand pair per cycle. It feeds each adder result back as the next accumulator value and publishes the final mix with a one-cycle done pulse. It sits between the band filter outputs and the output gain stage. The adder itself is external and combinational.

## Interface
- Width, 16, sample and accumulator width in bits (two's complement)
- Bands, 5, number of equalizer bands mixed per sample (2..8)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset. Sampled on rising edge of clk.
- start  in  1  one-cycle strobe: new band set is valid on band_data/band_en
- band_data  in  Bands*Width  flat band words, band k at bits [k*Width +: Width]
- band_en  in  Bands  per-band enable, 1 = include band in mix
- sum_a  out  Width  operand A to the shared saturating adder (accumulator)
- sum_b  out  Width  operand B to the shared saturating adder (current band)
- sum_y  in  Width  saturated result from the shared adder (combinational from sum_a/sum_b)
- mix_out  out  Width  registered mixed sample, held until the next done
- done  out  1  one-cycle pulse: mix_out updated this cycle
- busy  out  1  high while a mix is in progress (ACC or DONE)
- clip  out  1  registered with mix_out: 1 if any accumulation step saturated

## Operation
- States:
  - IDLE:
    - busy=0.
    - On start: capture band_data and band_en into internal registers, acc<=0, idx<=0, intermediate clip flag<=0, go to ACC.
  - ACC:
    - Drive sum_a=acc and sum_b = band_en_r[idx] ? band_r[idx] : 0.
    - acc<=sum_y, idx<=idx+1.
    - When idx==Bands-1, go to DONE.
  - DONE:
    - mix_out<=acc, clip<=intermediate flag, done=1, then go to IDLE.
- Accumulation order is fixed: index 0 to Bands-1.
  - The result equals the sequential saturating sum in that order, not the saturated true sum. Example: 0x7FFF saturation followed by a negative band reduces from 0x7FFF.
- Clip detection:
  - Each ACC cycle, the block forms a Width+1-bit sign-extended sum of sum_a and sum_b.
  - If that sum differs from sign-extended sum_y, the intermediate flag is set (sticky until the next start).
- sum_a and sum_b are 0 in IDLE and DONE.
- Disabled bands still consume their ACC cycle with operand 0. Latency is independent of band_en.
- start is accepted only in IDLE. start in ACC or DONE is ignored and not queued. band_data and band_en are don't-care outside the start cycle.
- Reset:
  - rst_n=0 forces IDLE. acc, idx, mix_out and clip go to 0. done and busy go to 0.
  - Reset mid-operation aborts the mix: no done pulse, and mix_out is cleared.
  - Reset takes priority over start in the same cycle.

## Timing
- Start accepted at edge 0. ACC occupies cycles 1..Bands. DONE is cycle Bands+1, with done high and mix_out valid there.
- Throughput: one mix per Bands+2 cycles. The earliest next accepted start is the first cycle after DONE (IDLE).
- mix_out and clip change only on the cycle done is high, and hold otherwise.
- Combinational path per ACC cycle: band mux to adder to acc register. No combinational path from start to any output.
- busy is registered: high from cycle 1 through cycle Bands+1 inclusive.

## Test plan
- Basic mix (Bands=5, all enabled):
  - Stimulus: bands 100, 200, -50, 0, 25.
  - Required: done at cycle 6, mix_out=275, clip=0. busy high in cycles 1..6.
- Ordered saturation:
  - Stimulus: bands 0x7000, 0x7000, 0x8000, 0, 0.
  - Required: acc goes 0x7000, then 0x7FFF, then 0xFFFF. Final mix_out=0xFFFF (-1), clip=1.
- Masked mix:
  - Stimulus: band_en=5'b00101, bands 10, 20, 30, 40, 50.
  - Required: mix_out=40, done still at cycle 6. sum_b=0 during idx 1, 3, 4.
- Start while busy:
  - Stimulus: second start at cycles 3 and 6 with different data.
  - Required: both ignored, first result unchanged. A start at cycle 7 is accepted, and its done comes at cycle 13.
- Reset mid-operation:
  - Stimulus: rst_n low at cycle 3 for one cycle.
  - Required: from the next edge, state is IDLE, mix_out=0, clip=0, busy=0. No done pulse. A new start then completes normally.
- Negative underflow:
  - Stimulus: bands 0x8000, -1, 5, 0, 0.
  - Required: acc goes 0x8000, then 0x8000 (saturated), then 0x8005. mix_out=0x8005, clip=1.
